// File: rtl/ka60_seq_ctrl_if.sv
// Handshake bundle between the top-level multiplier FSM, the Karatsuba sequencer
// and the shared 30x30 carry-less multiplier pipeline.
`timescale 1ns/1ps
interface ka60_seq_ctrl_if;
    localparam int unsigned N  = 60;
    localparam int unsigned H  = N / 2;
    localparam int unsigned PW = 2 * H - 1;
    localparam int unsigned OW = 2 * N - 1;

    logic          start;
    logic [N-1:0]  a_in;
    logic [N-1:0]  b_in;
    logic          busy;
    logic          done;
    logic [OW-1:0] product;
    logic [H-1:0]  mul_a;
    logic [H-1:0]  mul_b;
    logic          mul_valid;
    logic [PW-1:0] mul_res;
    logic          mul_res_valid;

    modport master (
        output start, a_in, b_in, mul_res, mul_res_valid,
        input  busy, done, product, mul_a, mul_b, mul_valid
    );

    modport slave (
        input  start, a_in, b_in, mul_res, mul_res_valid,
        output busy, done, product, mul_a, mul_b, mul_valid
    );
endinterface

// File: rtl/ka60_seq_ctrl.sv
// One Karatsuba level for a 60x60 GF(2) multiply: three half-width products are
// issued in sequence to a shared pipelined multiplier and recombined into 119 bits.
`timescale 1ns/1ps
module overlap_module_59bit (
    input  logic [58:0]  in1,
    input  logic [58:0]  in2,
    input  logic [58:0]  in3,
    output logic [118:0] out
);
    assign out = {60'd0, in1} ^ {30'd0, in2, 30'd0} ^ {in3, 60'd0};
endmodule

module ka60_seq_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    ka60_seq_ctrl_if.slave   bus
);
    localparam int unsigned N  = 60;
    localparam int unsigned H  = N / 2;
    localparam int unsigned PW = 2 * H - 1;
    localparam int unsigned OW = 2 * N - 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMBINE, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  a_q, a_nxt, b_q, b_nxt;
    logic [1:0]    iss_cnt, iss_cnt_nxt, res_cnt, res_cnt_nxt;
    logic [PW-1:0] p0, p0_nxt, p2, p2_nxt, pm, pm_nxt;
    logic [PW-1:0] mid_c;
    logic [OW-1:0] prod_c;
    logic          capture_c, last_res_c;
    logic          busy_nxt, done_nxt, mul_valid_nxt;
    logic [H-1:0]  mul_a_nxt, mul_b_nxt;

    assign mid_c = pm ^ p0 ^ p2;

    overlap_module_59bit u_overlap (
        .in1 (p0),
        .in2 (mid_c),
        .in3 (p2),
        .out (prod_c)
    );

    // Next state, result steering and the next-cycle values of the registered outputs.
    always_comb begin
        state_nxt     = state;
        a_nxt         = a_q;
        b_nxt         = b_q;
        iss_cnt_nxt   = iss_cnt;
        res_cnt_nxt   = res_cnt;
        p0_nxt        = p0;
        p2_nxt        = p2;
        pm_nxt        = pm;
        mul_a_nxt     = '0;
        mul_b_nxt     = '0;
        capture_c     = ((state == ISSUE) || (state == WAIT)) && bus.mul_res_valid
                        && (res_cnt != 2'd3);
        last_res_c    = capture_c && (res_cnt == 2'd2);

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    a_nxt       = bus.a_in;
                    b_nxt       = bus.b_in;
                    iss_cnt_nxt = '0;
                    res_cnt_nxt = '0;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                iss_cnt_nxt = iss_cnt + 2'd1;
                if (iss_cnt == 2'd2) state_nxt = last_res_c ? COMBINE : WAIT;
            end
            WAIT: begin
                if (last_res_c || (res_cnt == 2'd3)) state_nxt = COMBINE;
            end
            COMBINE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (capture_c) begin
            unique case (res_cnt)
                2'd0:    p0_nxt = bus.mul_res;
                2'd1:    p2_nxt = bus.mul_res;
                default: pm_nxt = bus.mul_res;
            endcase
            res_cnt_nxt = res_cnt + 2'd1;
        end

        mul_valid_nxt = (state_nxt == ISSUE);
        busy_nxt      = (state_nxt != IDLE);
        done_nxt      = (state_nxt == DONE);

        // Issue order P0, P2, Pm; operands come from the values being latched this cycle.
        if (mul_valid_nxt) begin
            unique case (iss_cnt_nxt)
                2'd0: begin
                    mul_a_nxt = a_nxt[H-1:0];
                    mul_b_nxt = b_nxt[H-1:0];
                end
                2'd1: begin
                    mul_a_nxt = a_nxt[N-1:H];
                    mul_b_nxt = b_nxt[N-1:H];
                end
                2'd2: begin
                    mul_a_nxt = a_nxt[H-1:0] ^ a_nxt[N-1:H];
                    mul_b_nxt = b_nxt[H-1:0] ^ b_nxt[N-1:H];
                end
                default: begin
                    mul_a_nxt = '0;
                    mul_b_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            iss_cnt       <= '0;
            res_cnt       <= '0;
            p0            <= '0;
            p2            <= '0;
            pm            <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mul_valid <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.product   <= '0;
        end else begin
            state         <= state_nxt;
            a_q           <= a_nxt;
            b_q           <= b_nxt;
            iss_cnt       <= iss_cnt_nxt;
            res_cnt       <= res_cnt_nxt;
            p0            <= p0_nxt;
            p2            <= p2_nxt;
            pm            <= pm_nxt;
            bus.busy      <= busy_nxt;
            bus.done      <= done_nxt;
            bus.mul_valid <= mul_valid_nxt;
            bus.mul_a     <= mul_a_nxt;
            bus.mul_b     <= mul_b_nxt;
            if (state == COMBINE) bus.product <= prod_c;
        end
    end
endmodule

// File: tb/tb_ka60_seq_ctrl.sv
// Scoreboard bench for ka60_seq_ctrl: a behavioural shared-multiplier model with
// selectable latency, a bitwise carry-less reference and a done-driven monitor.
`timescale 1ns/1ps
module tb_ka60_seq_ctrl;
    typedef struct {
        int          due;
        logic [58:0] val;
    } mres_t;

    typedef struct {
        logic [118:0] prod;
        int           due;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    lat         = 1;
    bit    stray_en    = 1'b0;
    mres_t pipe[$];
    exp_t  sb[$];

    always #5 clk = ~clk;

    ka60_seq_ctrl_if bus ();

    ka60_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [118:0] clmul60(input logic [59:0] a, input logic [59:0] b);
        logic [118:0] r = '0;
        for (int i = 0; i < 60; i++)
            if (b[i]) r = r ^ (119'(a) << i);
        return r;
    endfunction

    function automatic logic [58:0] clmul30(input logic [29:0] a, input logic [29:0] b);
        logic [58:0] r = '0;
        for (int i = 0; i < 30; i++)
            if (b[i]) r = r ^ (59'(a) << i);
        return r;
    endfunction

    function automatic logic [59:0] rand60();
        return 60'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shared multiplier: an issue in cycle c returns its product during cycle c+lat.
    always @(negedge clk) begin
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
            bus.mul_res_valid = 1'b1;
            bus.mul_res       = pipe[0].val;
            void'(pipe.pop_front());
        end else if (stray_en) begin
            bus.mul_res_valid = 1'b1;
            bus.mul_res       = 59'({$urandom(), $urandom()});
        end else begin
            bus.mul_res_valid = 1'b0;
            bus.mul_res       = '0;
        end
        if (bus.mul_valid === 1'b1)
            pipe.push_back('{cyc + lat, clmul30(bus.mul_a, bus.mul_b)});
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("product", 128'(bus.product), 128'(e.prod));
                chk("done_cycle", 128'(cyc), 128'(e.due));
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("done_timeout", 128'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic wait_pipe_empty();
        int n = 0;
        while (pipe.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("pipe_drain_timeout", 128'(pipe.size()), 0);
    endtask

    // Called at a negedge while idle; issues one op and optionally checks every cycle.
    task automatic run_op(input logic [59:0] a, input logic [59:0] b, input int l,
                          input bit cycle_chk);
        int t;
        lat       = l;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        t         = cyc;
        sb.push_back('{clmul60(a, b), t + 5 + l});
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = rand60();
        bus.b_in  = rand60();
        if (cycle_chk) begin
            for (int c = t + 1; c <= t + 5 + l; c++) begin
                chk("busy_during_op", 128'(bus.busy), 1);
                chk("mul_valid_window", 128'(bus.mul_valid), 128'(c <= t + 3));
                if (c > t + 3) chk("mul_a_idle_zero", 128'(bus.mul_a), 0);
                @(negedge clk);
            end
            chk("busy_after_done", 128'(bus.busy), 0);
            chk("done_single_pulse", 128'(bus.done), 0);
        end
        wait_drain();
    endtask

    initial begin
        int t;
        logic [59:0] a2, b2;
        logic [59:0] ones;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        chk("rst_busy", 128'(bus.busy), 0);
        chk("rst_done", 128'(bus.done), 0);
        chk("rst_mul_valid", 128'(bus.mul_valid), 0);
        chk("rst_mul_a", 128'(bus.mul_a), 0);
        chk("rst_mul_b", 128'(bus.mul_b), 0);
        chk("rst_product", 128'(bus.product), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(60'd1, 60'd1, 3, 1'b1);
        run_op(60'd3, 60'd3, 1, 1'b1);
        chk("x2_plus_1", 128'(bus.product), 128'd5);
        run_op(60'd1 << 59, 60'd1 << 59, 4, 1'b1);
        run_op(60'd1 << 59, 60'd1, 4, 1'b1);
        chk("mid_term_only", 128'(bus.product), 128'(119'd1 << 59));

        // Start held high across two operations.
        lat       = 2;
        a2        = rand60();
        b2        = rand60();
        bus.a_in  = rand60();
        bus.b_in  = rand60();
        bus.start = 1'b1;
        t         = cyc;
        sb.push_back('{clmul60(bus.a_in, bus.b_in), t + 7});
        sb.push_back('{clmul60(a2, b2), t + 15});
        @(negedge clk);
        bus.a_in = a2;
        bus.b_in = b2;
        while (cyc < t + 8) @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();

        // Asynchronous reset while waiting on results.
        lat       = 5;
        bus.a_in  = rand60();
        bus.b_in  = rand60();
        bus.start = 1'b1;
        t         = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t + 4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", 128'(bus.busy), 0);
        chk("abort_done", 128'(bus.done), 0);
        chk("abort_mul_valid", 128'(bus.mul_valid), 0);
        chk("abort_mul_a", 128'(bus.mul_a), 0);
        chk("abort_mul_b", 128'(bus.mul_b), 0);
        chk("abort_product", 128'(bus.product), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_pipe_empty();
        repeat (3) @(negedge clk);
        chk("late_results_ignored_busy", 128'(bus.busy), 0);
        chk("late_results_ignored_product", 128'(bus.product), 0);
        ones = '1;
        run_op(ones, ones, 5, 1'b1);

        // Stray result strobes while idle.
        stray_en = 1'b1;
        repeat (6) @(negedge clk);
        stray_en = 1'b0;
        @(negedge clk);
        chk("stray_no_busy", 128'(bus.busy), 0);
        run_op(rand60(), rand60(), 3, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic [59:0] ra, rb;
            ra = rand60();
            rb = rand60();
            if ($urandom_range(0, 15) == 0) ra = '1;
            if ($urandom_range(0, 15) == 0) rb = 60'd1 << $urandom_range(0, 59);
            run_op(ra, rb, int'($urandom_range(1, 6)), (i % 97) == 0);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
